// File: rtl/nv_fifo_rwsp_16x256_ctrl.sv
// Valid/ready FIFO controller driving an external 16x256 two-port RAM whose read
// path is two registers deep (address captured on ram_re, output captured on ram_ore).
module nv_fifo_rwsp_16x256_ctrl #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic             ram_we,
  output logic [3:0]       ram_wa,
  output logic [WIDTH-1:0] ram_di,
  output logic             ram_re,
  output logic [3:0]       ram_ra,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [4:0]       occ
);

  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [4:0] occ_q, occ_d;
  logic [4:0] avail_q, avail_d;
  logic       s1_vld_q, s1_vld_d;
  logic       s2_vld_q, s2_vld_d;

  logic push;
  logic s1_adv;
  logic issue;
  logic full;

  // wr_prdy depends on registered occupancy only, so a pop never opens a slot in the same cycle.
  assign full    = (occ_q == 5'(DEPTH));
  assign wr_prdy = !full;
  assign push    = wr_pvld && !full;

  assign s1_adv  = s1_vld_q && (!s2_vld_q || rd_prdy);
  assign issue   = (avail_q != 5'd0) && (!s1_vld_q || s1_adv);

  assign ram_we  = push;
  assign ram_wa  = wr_ptr_q;
  assign ram_di  = wr_pd;
  assign ram_re  = issue;
  assign ram_ra  = rd_ptr_q;
  assign ram_ore = s1_adv;
  assign rd_pvld = s2_vld_q;
  assign rd_pd   = ram_dout;
  assign occ     = occ_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    avail_d  = avail_q;
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;

    if (push)  wr_ptr_d = wr_ptr_q + 4'd1;
    if (issue) rd_ptr_d = rd_ptr_q + 4'd1;

    // avail counts entries written but not yet sent to the read-address register.
    case ({push, issue})
      2'b10:   avail_d = avail_q + 5'd1;
      2'b01:   avail_d = avail_q - 5'd1;
      default: avail_d = avail_q;
    endcase

    // An issued entry keeps its RAM slot until the output register has captured it.
    case ({push, s1_adv})
      2'b10:   occ_d = occ_q + 5'd1;
      2'b01:   occ_d = occ_q - 5'd1;
      default: occ_d = occ_q;
    endcase

    if (issue)       s1_vld_d = 1'b1;
    else if (s1_adv) s1_vld_d = 1'b0;

    if (s1_adv)       s2_vld_d = 1'b1;
    else if (rd_prdy) s2_vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      occ_q    <= 5'd0;
      avail_q  <= 5'd0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      avail_q  <= avail_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

endmodule

// File: tb/tb_nv_fifo_rwsp_16x256_ctrl.sv
// Directed + randomized bench for nv_fifo_rwsp_16x256_ctrl with a behavioural RAM
// and a queue-based reference model of the FIFO contents.
module tb_nv_fifo_rwsp_16x256_ctrl;

  logic         clk;
  logic         rst;
  logic         wr_pvld;
  logic         wr_prdy;
  logic [255:0] wr_pd;
  logic         rd_pvld;
  logic         rd_prdy;
  logic [255:0] rd_pd;
  logic         ram_we;
  logic [3:0]   ram_wa;
  logic [255:0] ram_di;
  logic         ram_re;
  logic [3:0]   ram_ra;
  logic         ram_ore;
  logic [255:0] ram_dout;
  logic [4:0]   occ;

  nv_fifo_rwsp_16x256_ctrl #(.DEPTH(16), .WIDTH(256)) dut (
    .clk(clk), .rst(rst),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore),
    .ram_dout(ram_dout), .occ(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-port RAM with registered read address and registered output.
  logic [255:0] mem [16];
  logic [3:0]   ra_reg;
  logic [255:0] dout_reg;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_reg <= ram_ra;
    if (ram_ore) dout_reg <= mem[ra_reg];
  end
  assign ram_dout = dout_reg;

  int total = 0;
  int bad   = 0;

  logic [255:0] q[$];
  int wr_cnt, re_cnt, ore_cnt;
  logic         prev_stall;
  logic [255:0] prev_pd;

  logic         o_push, o_pop, o_re, o_ore, o_pvld, o_prdy;
  logic [3:0]   o_ra;
  logic [4:0]   o_occ;
  logic [255:0] o_pd;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    wr_cnt = 0; re_cnt = 0; ore_cnt = 0;
    prev_stall = 1'b0;
  endtask

  // One clock cycle: sample at the falling edge, check against the model, advance.
  task automatic tick();
    @(negedge clk);
    o_push = wr_pvld && wr_prdy;
    o_pop  = rd_pvld && rd_prdy;
    o_re   = ram_re;
    o_ra   = ram_ra;
    o_ore  = ram_ore;
    o_pvld = rd_pvld;
    o_pd   = rd_pd;
    o_occ  = occ;
    o_prdy = wr_prdy;
    chk("held", int'(occ) + int'(rd_pvld), q.size());
    chk("occ_max", occ <= 5'd16, 1);
    chk("we", ram_we, o_push);
    chk("di", ram_di, wr_pd);
    chk("pd_wire", rd_pd, ram_dout);
    if (o_push) begin
      chk("wa", ram_wa, wr_cnt % 16);
      chk("no_overwrite", (wr_cnt - ore_cnt) < 16, 1);
    end
    if (o_re) begin
      chk("ra", ram_ra, re_cnt % 16);
      chk("re_written", re_cnt < wr_cnt, 1);
    end
    if (o_ore) chk("ore_issued", ore_cnt < re_cnt, 1);
    if (prev_stall) begin
      chk("stall_vld", rd_pvld, 1);
      chk("stall_pd", rd_pd, prev_pd);
    end
    if (o_pop && q.size() > 0) begin
      chk("data", rd_pd, q[0]);
      void'(q.pop_front());
    end
    if (o_push) q.push_back(wr_pd);
    wr_cnt  += int'(o_push);
    re_cnt  += int'(o_re);
    ore_cnt += int'(o_ore);
    prev_stall = rd_pvld && !rd_prdy;
    prev_pd    = rd_pd;
    @(posedge clk);
    #1;
  endtask

  // Single push into an empty FIFO, consumer always ready: data out exactly in cycle 3.
  task automatic lat_test(input logic [255:0] v);
    wr_pvld = 1'b1; wr_pd = v; rd_prdy = 1'b1;
    tick(); chk("lat_push", o_push, 1);
    wr_pvld = 1'b0;
    tick(); chk("lat_re1", o_re, 1); chk("lat_ra1", o_ra, 0); chk("lat_ore1", o_ore, 0); chk("lat_vld1", o_pvld, 0);
    tick(); chk("lat_ore2", o_ore, 1); chk("lat_re2", o_re, 0); chk("lat_vld2", o_pvld, 0);
    tick(); chk("lat_vld3", o_pvld, 1); chk("lat_pd3", o_pd, v);
    tick(); chk("lat_vld4", o_pvld, 0);
  endtask

  task automatic drain();
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    for (int i = 0; i < 60 && q.size() > 0; i++) tick();
    tick();
    chk("drain_empty", q.size(), 0);
    chk("drain_vld", o_pvld, 0);
  endtask

  initial begin
    int n, pops, pc, pp;
    logic full_seen;
    logic [255:0] pd0;
    rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prdy", wr_prdy, 1);
    chk("rst_pvld", rd_pvld, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_ore", ram_ore, 0);
    chk("rst_occ", occ, 0);
    chk("rst_we0", ram_we, 0);
    wr_pvld = 1'b1; #1;
    chk("rst_we1", ram_we, 1);
    wr_pvld = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    lat_test({32{8'hA5}});

    // Fill with consumer stalled: 16 RAM entries + 1 output register.
    rd_prdy = 1'b0; wr_pvld = 1'b1; n = 0;
    for (int i = 0; i < 22; i++) begin
      wr_pd = {8{n}};
      tick();
      if (o_push) n++;
    end
    chk("fill_n", n, 17);
    chk("fill_occ", o_occ, 16);
    chk("fill_prdy", o_prdy, 0);
    wr_pvld = 1'b0; rd_prdy = 1'b1; pops = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      pops += int'(o_pop);
    end
    chk("drain_n", pops, 17);
    drain();

    // Random backpressure stream of 40 values.
    n = 0;
    for (int i = 0; i < 400 && (n < 40 || q.size() > 0); i++) begin
      wr_pvld = (n < 40);
      wr_pd   = {8{n + 100}};
      rd_prdy = (n < 40) ? 1'($urandom % 2) : 1'b1;
      tick();
      if (o_push) n++;
    end
    chk("str_n", n, 40);
    chk("str_empty", q.size(), 0);

    // Full FIFO with both sides active.
    rd_prdy = 1'b0; wr_pvld = 1'b1; full_seen = 1'b0; n = 0;
    for (int i = 0; i < 40 && !full_seen; i++) begin
      wr_pd = {8{32'h5000 + n}};
      tick();
      if (o_push) n++;
      if (!o_prdy) full_seen = 1'b1;
    end
    chk("ff_full", full_seen, 1);
    rd_prdy = 1'b1; pc = 0; pp = 0;
    for (int i = 0; i < 25; i++) begin
      wr_pd = {8{32'h5000 + n}};
      tick();
      if (o_push) n++;
      if (i >= 5) begin
        pc += int'(o_push);
        pp += int'(o_pop);
        chk("ff_occ", (o_occ == 5'd15) || (o_occ == 5'd16), 1);
      end
    end
    chk("ff_push", pc, 20);
    chk("ff_pop", pp, 20);
    drain();

    // Reset in the middle of traffic.
    rd_prdy = 1'b0; wr_pvld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_pd = {8{32'h700 + i}};
      tick();
    end
    wr_pvld = 1'b0;
    for (int i = 0; i < 10 && !o_pvld; i++) tick();
    chk("mr_vld", o_pvld, 1);
    rd_prdy = 1'b1; pops = 0;
    for (int i = 0; i < 10 && pops < 2; i++) begin
      tick();
      pops += int'(o_pop);
    end
    rd_prdy = 1'b0;
    chk("mr_pops", pops, 2);
    #2 rst = 1'b1;
    #1;
    chk("mr_rst_vld", rd_pvld, 0);
    chk("mr_rst_occ", occ, 0);
    chk("mr_rst_prdy", wr_prdy, 1);
    model_clear();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    lat_test(256'h1);

    // Hold a word in the output register for 10 stalled cycles.
    rd_prdy = 1'b0; wr_pvld = 1'b1;
    wr_pd = {8{32'hDEAD0001}}; tick();
    wr_pd = {8{32'hDEAD0002}}; tick();
    wr_pvld = 1'b0;
    for (int i = 0; i < 10 && !o_pvld; i++) tick();
    chk("idle_vld", o_pvld, 1);
    pd0 = o_pd;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ore", o_ore, 0);
      chk("idle_pd", o_pd, pd0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
